regbank8_wr_16b: RTL and testbench

- Write-side counterpart to the 8:1 16-bit read-select path: decodes a 3-bit write address and steers 16-bit data into one of eight registers.
- Drives all eight register values in parallel (OutA..OutH), ready to feed an 8:1 read mux.
- Registered write stage with a forwarding tap, one-write-per-cycle handshake, and a command-driven clear sweep FSM.
- Sits in the write-back end of the datapath.

---
 rtl/regbank8_wr_16b.sv | 127 ++++++++++++
 tb/tb_regbank8_wr_16b.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank8_wr_16b.sv
// rtl/regbank8_wr_16b.sv - eight-entry write-side register bank with staged writes and clear sweep
// Writes pass through a one-deep stage register (forwarding tap) before committing to Out*.
module regbank8_wr_16b #(
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             pend_valid,
  output logic [2:0]       pend_addr,
  output logic [WIDTH-1:0] pend_data,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic [WIDTH-1:0] OutE,
  output logic [WIDTH-1:0] OutF,
  output logic [WIDTH-1:0] OutG,
  output logic [WIDTH-1:0] OutH
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic [2:0]       pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic             accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = 3'd0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Stage register holds its last contents when idle so unused inputs never leak in.
  always_comb begin
    accept       = wr_en && (state_q == IDLE);
    pend_valid_d = accept;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (accept) begin
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end
  end

  // Sweep write is applied last so it overrides a colliding commit.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (pend_valid_q) begin
      regs_d[pend_addr_q] = pend_data_q;
    end
    if (state_q == SWEEP) begin
      regs_d[cnt_q] = CLR_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 3'd0;
      pend_data_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign wr_ready   = (state_q == IDLE);
  assign clr_busy   = (state_q == SWEEP);
  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;

  assign OutA = regs_q[0];
  assign OutB = regs_q[1];
  assign OutC = regs_q[2];
  assign OutD = regs_q[3];
  assign OutE = regs_q[4];
  assign OutF = regs_q[5];
  assign OutG = regs_q[6];
  assign OutH = regs_q[7];

endmodule

// File: tb/tb_regbank8_wr_16b.sv
// tb/tb_regbank8_wr_16b.sv - scoreboard bench for regbank8_wr_16b
// Accepted writes are queued by the driver and popped when pend_valid appears.
module tb_regbank8_wr_16b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0;
  logic        clr_req = 1'b0;
  logic        wr_ready, clr_busy, pend_valid;
  logic [2:0]  pend_addr;
  logic [15:0] pend_data;
  logic [15:0] OutA, OutB, OutC, OutD, OutE, OutF, OutG, OutH;
  logic [15:0] outs [8];
  logic [15:0] mdl [8];
  logic [18:0] sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  regbank8_wr_16b dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data),
    .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
    .OutE(OutE), .OutF(OutF), .OutG(OutG), .OutH(OutH)
  );

  always #5 clk = ~clk;

  assign outs[0] = OutA;
  assign outs[1] = OutB;
  assign outs[2] = OutC;
  assign outs[3] = OutD;
  assign outs[4] = OutE;
  assign outs[5] = OutF;
  assign outs[6] = OutG;
  assign outs[7] = OutH;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_out%0d", tag, i), {16'h0, outs[i]}, {16'h0, mdl[i]});
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
  endtask

  // Each call presents one write for one edge; consecutive calls are back-to-back.
  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (wr_ready) sb_q.push_back({a, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_en   = 1'b0;
    clr_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_sweep_done(input string tag);
    int cyc = 0;
    while (clr_busy && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_sweep_done"}, {31'h0, clr_busy}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && pend_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("pend_unexpected", {31'h0, pend_valid}, 32'h0);
      end else begin
        logic [18:0] e;
        e = sb_q.pop_front();
        check_eq("pend_addr", {29'h0, pend_addr}, {29'h0, e[18:16]});
        check_eq("pend_data", {16'h0, pend_data}, {16'h0, e[15:0]});
        mdl[e[18:16]] = e[15:0];
      end
    end
  end

  initial begin
    mdl_clear();
    #12 rst = 1'b0;
    @(negedge clk);
    check_eq("init_ready", {31'h0, wr_ready}, 32'h1);
    check_eq("init_busy", {31'h0, clr_busy}, 32'h0);

    // Mid-cycle async reset clears a previously written value immediately.
    do_write(3'd1, 16'h55AA);
    idle(2);
    check_all("prewr");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    mdl_clear();
    sb_q.delete();
    check_all("rst");
    check_eq("rst_pend_valid", {31'h0, pend_valid}, 32'h0);
    check_eq("rst_ready", {31'h0, wr_ready}, 32'h1);
    check_eq("rst_busy", {31'h0, clr_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single write: forwarding after one edge, commit after two.
    do_write(3'd5, 16'hBEEF);
    wr_en = 1'b0;
    check_eq("single_pend_valid", {31'h0, pend_valid}, 32'h1);
    check_eq("single_outf_early", {16'h0, OutF}, 32'h0);
    idle(1);
    check_eq("single_pend_drop", {31'h0, pend_valid}, 32'h0);
    check_all("single");

    // Back-to-back fill, then same-address ordering.
    for (int i = 0; i < 8; i++) do_write(i[2:0], 16'h1000 + 16'(i));
    idle(2);
    check_all("b2b");
    do_write(3'd3, 16'hAAAA);
    do_write(3'd3, 16'h5555);
    idle(2);
    check_all("same_addr");
    check_eq("same_addr_outd", {16'h0, OutD}, 32'h5555);

    // Clear sweep with a write request held against it.
    for (int i = 0; i < 8; i++) do_write(i[2:0], 16'hFFFF);
    idle(2);
    check_all("preload");
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 16'h7777;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("sweep_busy%0d", k), {31'h0, clr_busy}, 32'h1);
      check_eq($sformatf("sweep_ready%0d", k), {31'h0, wr_ready}, 32'h0);
      if (k > 0) check_eq($sformatf("sweep_clr%0d", k - 1), {16'h0, outs[k - 1]}, 32'h0);
      check_eq($sformatf("sweep_keep%0d", k), {16'h0, outs[k]}, 32'hFFFF);
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("sweep_end_busy", {31'h0, clr_busy}, 32'h0);
    check_eq("sweep_end_ready", {31'h0, wr_ready}, 32'h1);
    wr_en = 1'b0;
    mdl_clear();
    check_all("sweep");
    idle(2);
    check_all("sweep_post");

    // Simultaneous clear and write to reg 0: the sweep write wins the collision.
    do_write(3'd0, 16'h1111);
    do_write(3'd4, 16'h4444);
    idle(2);
    check_all("coll_pre");
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 16'h1234;
    clr_req = 1'b1;
    if (wr_ready) sb_q.push_back({3'd0, 16'h1234});
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    clr_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("coll_outa", {16'h0, OutA}, 32'h0);
    wait_sweep_done("coll");
    mdl_clear();
    check_all("coll");

    // Reset while the sweep counter sits at 4.
    do_write(3'd6, 16'h6666);
    do_write(3'd7, 16'h7777);
    idle(2);
    check_all("mid_pre");
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    mdl_clear();
    check_all("midrst");
    check_eq("midrst_ready", {31'h0, wr_ready}, 32'h1);
    check_eq("midrst_busy", {31'h0, clr_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_write(3'd6, 16'hC0DE);
    idle(2);
    check_all("midrst_wr");
    check_eq("midrst_outg", {16'h0, OutG}, 32'hC0DE);
    check_eq("sb_empty", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
